// File: rtl/rat_recovery_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rat_recovery_ctrl_pkg
//  Purpose  : Shared constants and state encoding for the rename-table
//             recovery controller and its dirty-bit picker.
//  Contents : LREG_W (logical reg index width), default sizing parameters,
//             FSM state constants {IDLE, WALK, FIXUP}.
//  Revision : 1.0  initial release
// ============================================================================
package rat_recovery_ctrl_pkg;

  localparam int LREG_W         = 5;
  localparam int PREG_W_DEF     = 6;
  localparam int LREG_NUM_DEF   = 32;
  localparam int WALK_WIDTH_DEF = 2;

  localparam int STATE_W = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WALK  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;

endpackage : rat_recovery_ctrl_pkg
`default_nettype wire

// File: rtl/rat_dirty_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rat_dirty_pick
//  Purpose  : Combinational priority picker. Returns the WALK_WIDTH lowest
//             set bit positions of a LREG_NUM-bit vector plus a valid mask.
//  Ports    : dirty_vec  in  LREG_NUM            vector to search
//             pick_idx   out WALK_WIDTH*LREG_W   lane k = k-th lowest set bit
//             pick_valid out WALK_WIDTH          lane k found a bit
//  Revision : 1.0  initial release
// ============================================================================
module rat_dirty_pick
  import rat_recovery_ctrl_pkg::*;
#(
  parameter int LREG_NUM   = LREG_NUM_DEF,
  parameter int WALK_WIDTH = WALK_WIDTH_DEF
) (
  input  logic [LREG_NUM-1:0]          dirty_vec,
  output logic [WALK_WIDTH*LREG_W-1:0] pick_idx,
  output logic [WALK_WIDTH-1:0]        pick_valid
);

  logic [LREG_NUM-1:0] remain;
  logic                found;

  // Each lane takes the lowest bit still set, then removes it so the next
  // lane sees the following one. Unfound lanes report index 0.
  always_comb begin
    remain     = dirty_vec;
    pick_idx   = '0;
    pick_valid = '0;
    found      = 1'b0;
    for (int k = 0; k < WALK_WIDTH; k++) begin
      found = 1'b0;
      for (int b = 0; b < LREG_NUM; b++) begin
        if (!found && remain[b]) begin
          found                          = 1'b1;
          remain[b]                      = 1'b0;
          pick_idx[k*LREG_W +: LREG_W]   = LREG_W'(b);
          pick_valid[k]                  = 1'b1;
        end
      end
    end
  end

endmodule : rat_dirty_pick
`default_nettype wire

// File: rtl/rat_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rat_recovery_ctrl
//  Purpose  : After a flush, copies the architectural rename table into the
//             speculative rename table WALK_WIDTH entries per cycle, holding
//             rename until the copy is coherent. Entries committed after
//             being copied are tracked as dirty and re-copied in FIXUP.
//  Ports    : clock, reset (sync, active-high), flush_valid
//             commits{0,1}_rat_wren / _lrd    arch table updates
//             arat_rd_idx / arat_rd_data      arch table combinational read
//             srat_wr_en / _lrd / _prd        spec table recovery writes
//             rename_stall                    high in WALK and FIXUP
//             recover_done                    1-cycle pulse after FIXUP exit
//             perf_recover_cycles             (RAT_RECOVERY_PERF_EN only)
//  Macro    : RAT_RECOVERY_PERF_EN adds a saturating count of stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module rat_recovery_ctrl
  import rat_recovery_ctrl_pkg::*;
#(
  parameter int LREG_NUM   = LREG_NUM_DEF,
  parameter int PREG_W     = PREG_W_DEF,
  parameter int WALK_WIDTH = WALK_WIDTH_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush_valid,
  input  logic                          commits0_rat_wren,
  input  logic [LREG_W-1:0]             commits0_lrd,
  input  logic                          commits1_rat_wren,
  input  logic [LREG_W-1:0]             commits1_lrd,
  output logic [WALK_WIDTH*LREG_W-1:0]  arat_rd_idx,
  input  logic [WALK_WIDTH*PREG_W-1:0]  arat_rd_data,
  output logic [WALK_WIDTH-1:0]         srat_wr_en,
  output logic [WALK_WIDTH*LREG_W-1:0]  srat_wr_lrd,
  output logic [WALK_WIDTH*PREG_W-1:0]  srat_wr_prd,
  output logic                          rename_stall,
  output logic                          recover_done
`ifdef RAT_RECOVERY_PERF_EN
  ,
  output logic [31:0]                   perf_recover_cycles
`endif
);

  localparam logic [LREG_W-1:0] LAST_GROUP = LREG_W'(LREG_NUM - WALK_WIDTH);
  localparam logic [LREG_W-1:0] WALK_INC   = LREG_W'(WALK_WIDTH);
  localparam logic [LREG_W:0]   WALK_STEP  = (LREG_W+1)'(WALK_WIDTH);

  logic [STATE_W-1:0]          state_q, state_d;
  logic [LREG_W-1:0]           cursor_q, cursor_d;
  logic [LREG_NUM-1:0]         dirty_q, dirty_d;
  logic                        done_q, done_d;

  logic [WALK_WIDTH*LREG_W-1:0] pick_idx;
  logic [WALK_WIDTH-1:0]        pick_valid;
  logic [WALK_WIDTH*LREG_W-1:0] rd_idx;
  logic [WALK_WIDTH-1:0]        wr_en;
  logic [LREG_NUM-1:0]          set_vec;
  logic [LREG_NUM-1:0]          clr_vec;
  logic [LREG_W:0]              walk_limit;

  rat_dirty_pick #(
    .LREG_NUM   (LREG_NUM),
    .WALK_WIDTH (WALK_WIDTH)
  ) u_pick (
    .dirty_vec  (dirty_q),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // One past the highest entry copied by the end of this cycle. Arch read
  // data is the pre-write value, so the group being copied right now counts
  // as already copied.
  assign walk_limit = {1'b0, cursor_q} + WALK_STEP;

  always_comb begin
    rd_idx = '0;
    wr_en  = '0;
    case (state_q)
      ST_WALK: begin
        for (int k = 0; k < WALK_WIDTH; k++) begin
          rd_idx[k*LREG_W +: LREG_W] = cursor_q + LREG_W'(k);
          wr_en[k]                   = 1'b1;
        end
      end
      ST_FIXUP: begin
        rd_idx = pick_idx;
        wr_en  = pick_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (state_q == ST_WALK) begin
      if (commits0_rat_wren && ({1'b0, commits0_lrd} < walk_limit))
        set_vec[commits0_lrd] = 1'b1;
      if (commits1_rat_wren && ({1'b0, commits1_lrd} < walk_limit))
        set_vec[commits1_lrd] = 1'b1;
    end else if (state_q == ST_FIXUP) begin
      if (commits0_rat_wren) set_vec[commits0_lrd] = 1'b1;
      if (commits1_rat_wren) set_vec[commits1_lrd] = 1'b1;
      for (int k = 0; k < WALK_WIDTH; k++) begin
        if (pick_valid[k]) clr_vec[pick_idx[k*LREG_W +: LREG_W]] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    // A commit hitting an entry being re-copied keeps it dirty.
    dirty_d  = (dirty_q & ~clr_vec) | set_vec;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_valid) begin
          state_d  = ST_WALK;
          cursor_d = '0;
        end
      end
      ST_WALK: begin
        cursor_d = cursor_q + WALK_INC;
        if (cursor_q == LAST_GROUP) begin
          state_d  = ST_FIXUP;
          cursor_d = '0;
        end
      end
      ST_FIXUP: begin
        if ((dirty_q == '0) && (set_vec == '0)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush restarts the walk from scratch regardless of progress.
    if (flush_valid) begin
      state_d  = ST_WALK;
      cursor_d = '0;
      dirty_d  = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cursor_q <= '0;
      dirty_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      dirty_q  <= dirty_d;
      done_q   <= done_d;
    end
  end

  assign arat_rd_idx  = rd_idx;
  assign srat_wr_lrd  = rd_idx;
  assign srat_wr_en   = wr_en;
  assign srat_wr_prd  = arat_rd_data;
  assign rename_stall = (state_q != ST_IDLE);
  assign recover_done = done_q;

`ifdef RAT_RECOVERY_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (rename_stall && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_recover_cycles = perf_q;
`endif

endmodule : rat_recovery_ctrl
`default_nettype wire

// File: tb/tb_rat_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rat_recovery_ctrl
//  Purpose  : Randomized, scoreboard-checked bench for rat_recovery_ctrl.
//             The bench owns the architectural table memory, mirrors the
//             speculative table from the DUT write ports, and checks that the
//             copy is complete whenever recovery reports done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rat_recovery_ctrl;

  localparam int NREG = 32;
  localparam int PW   = 6;
  localparam int WW   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush_valid;
  logic            c0_wren, c1_wren;
  logic [4:0]      c0_lrd, c1_lrd;
  logic [WW*5-1:0] arat_rd_idx;
  logic [WW*PW-1:0] arat_rd_data;
  logic [WW-1:0]   srat_wr_en;
  logic [WW*5-1:0] srat_wr_lrd;
  logic [WW*PW-1:0] srat_wr_prd;
  logic            rename_stall;
  logic            recover_done;
`ifdef RAT_RECOVERY_PERF_EN
  logic [31:0]     perf_recover_cycles;
`endif

  always #5 clk = ~clk;

  rat_recovery_ctrl #(.LREG_NUM(NREG), .PREG_W(PW), .WALK_WIDTH(WW)) dut (
    .clock             (clk),
    .reset             (reset),
    .flush_valid       (flush_valid),
    .commits0_rat_wren (c0_wren),
    .commits0_lrd      (c0_lrd),
    .commits1_rat_wren (c1_wren),
    .commits1_lrd      (c1_lrd),
    .arat_rd_idx       (arat_rd_idx),
    .arat_rd_data      (arat_rd_data),
    .srat_wr_en        (srat_wr_en),
    .srat_wr_lrd       (srat_wr_lrd),
    .srat_wr_prd       (srat_wr_prd),
    .rename_stall      (rename_stall),
    .recover_done      (recover_done)
`ifdef RAT_RECOVERY_PERF_EN
    ,
    .perf_recover_cycles (perf_recover_cycles)
`endif
  );

  // Bench-owned architectural table and the mirror of the speculative table.
  logic [PW-1:0] arat_mem  [NREG];
  logic [PW-1:0] srat_copy [NREG];

  always_comb begin
    for (int k = 0; k < WW; k++)
      arat_rd_data[k*PW +: PW] = arat_mem[arat_rd_idx[k*5 +: 5]];
  end

  typedef struct {
    bit        stall;
    bit        done;
    bit [1:0]  en;
    bit        idle;
    bit [31:0] perf;
  } cyc_t;

  typedef struct {
    bit [4:0]  lrd;
    bit [PW-1:0] prd;
  } wr_t;

  cyc_t exp_cyc[$];
  wr_t  exp_wr[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model: phase 0=idle 1=copying 2=re-copying, next register to
  // copy, set of stale registers, pending done pulse, stall-cycle count.
  int        m_phase = 0;
  int        m_next  = 0;
  bit [31:0] m_dirty = '0;
  bit        m_done  = 1'b0;
  bit [31:0] m_perf  = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
  task automatic step(input bit f, input bit rs, input bit w0, input bit [4:0] l0,
                      input bit w1, input bit [4:0] l1);
    cyc_t      e;
    wr_t       w;
    int        picks[$];
    bit [31:0] setv;
    bit        nd;
    @(negedge clk);
    flush_valid = f;
    reset       = rs;
    c0_wren     = w0;
    c0_lrd      = l0;
    c1_wren     = w1;
    c1_lrd      = l1;
    mon_en      = 1'b1;

    e.stall = (m_phase != 0);
    e.done  = m_done;
    e.en    = '0;
    e.idle  = (m_phase == 0);
    e.perf  = m_perf;
    if (m_phase == 1) begin
      for (int k = 0; k < WW; k++) begin
        e.en[k] = 1'b1;
        w.lrd   = 5'(m_next + k);
        w.prd   = arat_mem[m_next + k];
        exp_wr.push_back(w);
      end
    end else if (m_phase == 2) begin
      for (int r = 0; r < NREG; r++)
        if (m_dirty[r] && picks.size() < WW) picks.push_back(r);
      foreach (picks[i]) begin
        e.en[i] = 1'b1;
        w.lrd   = 5'(picks[i]);
        w.prd   = arat_mem[picks[i]];
        exp_wr.push_back(w);
      end
    end
    exp_cyc.push_back(e);

    setv = '0;
    if (w0) setv[l0] = 1'b1;
    if (w1) setv[l1] = 1'b1;
    if (rs) begin
      m_phase = 0; m_next = 0; m_dirty = '0; m_done = 1'b0; m_perf = '0;
    end else begin
      nd = 1'b0;
      if (m_phase != 0 && m_perf != 32'hFFFF_FFFF) m_perf++;
      if (m_phase == 1) begin
        for (int r = 0; r < NREG; r++)
          if (setv[r] && r < m_next + WW) m_dirty[r] = 1'b1;
        m_next += WW;
        if (m_next == NREG) begin
          m_phase = 2;
          m_next  = 0;
        end
      end else if (m_phase == 2) begin
        if (m_dirty == 0 && setv == 0) begin
          m_phase = 0;
          nd      = 1'b1;
        end else begin
          foreach (picks[i]) m_dirty[picks[i]] = 1'b0;
          m_dirty |= setv;
        end
      end
      if (f) begin
        m_phase = 1; m_next = 0; m_dirty = '0; nd = 1'b0;
      end
      m_done = nd;
    end

    @(posedge clk);
    // The arch table takes commit writes at the edge, after the read.
    if (w0) arat_mem[l0] = PW'($urandom);
    if (w1) arat_mem[l1] = PW'($urandom);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic run_to_idle(input int budget);
    int n = 0;
    while (m_phase != 0 && n < budget) begin
      step(0, 0, 0, 5'd0, 0, 5'd0);
      n++;
    end
    n_checks++;
    if (m_phase != 0) begin
      n_fail++;
      $display("FAIL recovery_budget: still busy after %0d cycles, required idle", n);
    end
    step(0, 0, 0, 5'd0, 0, 5'd0);
  endtask

  // Monitor: one cycle record per clock, one write record per expected lane.
  initial begin
    cyc_t e;
    wr_t  w;
    int   nbad;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) continue;
      if (exp_cyc.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL cycle_queue: empty, required an expected record");
        continue;
      end
      e = exp_cyc.pop_front();
      chk("rename_stall", rename_stall, e.stall);
      chk("recover_done", recover_done, e.done);
      chk("srat_wr_en", srat_wr_en, e.en);
      if (e.idle) chk("idle_rd_idx", arat_rd_idx, 0);
`ifdef RAT_RECOVERY_PERF_EN
      chk("perf_recover_cycles", perf_recover_cycles, e.perf);
`endif
      for (int k = 0; k < WW; k++) begin
        if (e.en[k]) begin
          if (exp_wr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL write_queue: empty at lane %0d", k);
          end else begin
            w = exp_wr.pop_front();
            chk("srat_wr_lrd", srat_wr_lrd[k*5 +: 5], w.lrd);
            chk("srat_wr_prd", srat_wr_prd[k*PW +: PW], w.prd);
          end
        end
        if (srat_wr_en[k]) srat_copy[srat_wr_lrd[k*5 +: 5]] = srat_wr_prd[k*PW +: PW];
      end
      if (recover_done) begin
        nbad = 0;
        for (int r = 0; r < NREG; r++)
          if (srat_copy[r] !== arat_mem[r]) nbad++;
        chk("table_coherent_on_done", nbad, 0);
      end
    end
  end

  initial begin
    for (int r = 0; r < NREG; r++) begin
      arat_mem[r]  = PW'($urandom);
      srat_copy[r] = '0;
    end
    reset = 1'b1; flush_valid = 1'b0;
    c0_wren = 1'b0; c0_lrd = '0; c1_wren = 1'b0; c1_lrd = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 5'd0, 0, 5'd0);
    idle_steps(2);

    // Plain recovery, no commits.
    step(1, 0, 0, 5'd0, 0, 5'd0);
    run_to_idle(40);

    // Commit behind the cursor (lrd 3) and ahead of it (lrd 30) at walk cycle 5.
    step(1, 0, 0, 5'd0, 0, 5'd0);
    idle_steps(4);
    step(0, 0, 1, 5'd3, 1, 5'd30);
    run_to_idle(40);

    // Continuous commits during FIXUP keep it alive.
    step(1, 0, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 20 && m_phase == 1; i++) idle_steps(1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 5'd7, 1, 5'd9);
    run_to_idle(40);

    // Restart mid-walk.
    step(1, 0, 0, 5'd0, 0, 5'd0);
    idle_steps(7);
    step(1, 0, 1, 5'd1, 0, 5'd0);
    run_to_idle(40);

    // Reset during walk.
    step(1, 0, 0, 5'd0, 0, 5'd0);
    idle_steps(5);
    step(0, 1, 1, 5'd2, 0, 5'd0);
    idle_steps(3);

    // Two back-to-back recoveries after reset.
    step(1, 0, 0, 5'd0, 0, 5'd0);
    run_to_idle(40);
    step(1, 0, 0, 5'd0, 0, 5'd0);
    run_to_idle(40);
`ifdef RAT_RECOVERY_PERF_EN
    #1;
    chk("perf_two_recoveries", perf_recover_cycles, 34);
`endif

    // Flush coinciding with a done pulse.
    step(1, 0, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 40 && m_phase != 0; i++) idle_steps(1);
    step(1, 0, 0, 5'd0, 0, 5'd0);
    run_to_idle(40);

    // Random traffic.
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 3) == 0, 5'($urandom),
           $urandom_range(0, 3) == 0, 5'($urandom));
    step(1, 0, 0, 5'd0, 0, 5'd0);
    run_to_idle(200);
    idle_steps(2);

    mon_en = 1'b0;
    #10;
    chk("cycle_queue_drained", exp_cyc.size(), 0);
    chk("write_queue_drained", exp_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rat_recovery_ctrl
`default_nettype wire
